// File: rtl/sa_result_drain.sv
// Snapshots the systolic-array result bus on capture and streams it out one PE row per beat.
// The array can start its next computation as soon as the snapshot has been taken.
module sa_result_drain #(
    parameter  int WIDTH = 16,
    parameter  int HPE   = 16,
    parameter  int VPE   = 16,
    localparam int RW    = 2 * WIDTH,
    localparam int ROW_W = (VPE > 1) ? $clog2(VPE) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [RW*HPE*VPE-1:0]   Y,
    input  logic                    capture,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RW*HPE-1:0]       out_data,
    output logic [ROW_W-1:0]        out_row,
    output logic                    out_last,
    output logic [7:0]              drop_cnt
);

    localparam int NPE = HPE * VPE;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                          state_q, state_d;
    logic [ROW_W-1:0]                row_q, row_d;
    logic [VPE-1:0][RW*HPE-1:0]      shadow_q, shadow_d;
    logic [7:0]                      drop_q, drop_d;
    logic [VPE-1:0][RW*HPE-1:0]      y_rows;
    logic                            accept;
    logic                            last_row;

    // Regroup the flat bus (PE(0,0) in the MSBs) into rows with column 0 in the LSBs.
    always_comb begin
        y_rows = '0;
        for (int r = 0; r < VPE; r++) begin
            for (int c = 0; c < HPE; c++) begin
                y_rows[r][c*RW +: RW] = Y[(NPE-1-(r*HPE+c))*RW +: RW];
            end
        end
    end

    assign accept   = (state_q == DRAIN) && out_ready;
    assign last_row = (row_q == ROW_W'(VPE - 1));

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        shadow_d = shadow_q;
        drop_d   = drop_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    shadow_d = y_rows;
                    row_d    = '0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && last_row) begin
                    row_d = '0;
                    if (capture) begin
                        shadow_d = y_rows;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (accept) begin
                        row_d = row_q + 1'b1;
                    end
                    if (capture && (drop_q != 8'hFF)) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            row_q    <= '0;
            shadow_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            shadow_q <= shadow_d;
            drop_q   <= drop_d;
        end
    end

    assign busy      = (state_q == DRAIN);
    assign out_valid = busy;
    assign out_row   = row_q;
    assign out_last  = busy && last_row;
    assign out_data  = busy ? shadow_q[row_q] : '0;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: rows expected from each accepted capture are queued
// and compared against every presented beat, including stalls.
module tb_sa_result_drain;

    localparam int WIDTH = 16;
    localparam int HPE   = 16;
    localparam int VPE   = 16;
    localparam int RW    = 2 * WIDTH;
    localparam int NPE   = HPE * VPE;
    localparam int DW    = RW * HPE;

    typedef struct {
        logic [3:0]    row;
        logic [DW-1:0] data;
    } beat_t;

    logic                 CLK;
    logic                 RST;
    logic [RW*NPE-1:0]    Y;
    logic                 capture;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [3:0]           out_row;
    logic                 out_last;
    logic [7:0]           drop_cnt;

    logic [RW-1:0]        pe [VPE][HPE];
    beat_t                sb [$];
    int                   drop_m;
    int                   n_chk;
    int                   n_pass;
    int                   n_fail;
    logic [7:0]           drop_before;

    sa_result_drain #(.WIDTH(WIDTH), .HPE(HPE), .VPE(VPE)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Y         (Y),
        .capture   (capture),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack_y();
        for (int r = 0; r < VPE; r++)
            for (int c = 0; c < HPE; c++)
                Y[(NPE-(r*HPE+c))*RW-1 -: RW] = pe[r][c];
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < VPE; r++)
            for (int c = 0; c < HPE; c++)
                pe[r][c] = RW'(r * 256 + c);
        pack_y();
    endtask

    task automatic fill_const(input logic [RW-1:0] v);
        for (int r = 0; r < VPE; r++)
            for (int c = 0; c < HPE; c++)
                pe[r][c] = v;
        pack_y();
    endtask

    task automatic fill_random();
        for (int r = 0; r < VPE; r++)
            for (int c = 0; c < HPE; c++)
                pe[r][c] = $urandom;
        pack_y();
    endtask

    task automatic push_snapshot();
        beat_t b;
        for (int r = 0; r < VPE; r++) begin
            b.row  = 4'(r);
            b.data = '0;
            for (int c = 0; c < HPE; c++)
                b.data[c*RW +: RW] = pe[r][c];
            sb.push_back(b);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".busy"},      DW'(busy),      '0);
        chk({tag, ".valid"},     DW'(out_valid), '0);
        chk({tag, ".data"},      out_data,       '0);
        chk({tag, ".row"},       DW'(out_row),   '0);
        chk({tag, ".last"},      DW'(out_last),  '0);
        chk({tag, ".drop"},      DW'(drop_cnt),  '0);
    endtask

    // Called at a falling edge: check what is presented, drive inputs, advance the model one edge.
    task automatic tick(input logic cap, input logic rdy);
        logic have;
        have = (sb.size() > 0);
        chk("valid", DW'(out_valid), DW'(have));
        chk("busy",  DW'(busy),      DW'(have));
        chk("drop",  DW'(drop_cnt),  DW'(drop_m));
        if (have) begin
            chk("data", out_data,     sb[0].data);
            chk("row",  DW'(out_row), DW'(sb[0].row));
            chk("last", DW'(out_last), DW'(sb[0].row == 4'(VPE - 1)));
        end else begin
            chk("idle_row",  DW'(out_row),  '0);
            chk("idle_last", DW'(out_last), '0);
        end
        capture   = cap;
        out_ready = rdy;
        if (have && rdy) void'(sb.pop_front());
        if (cap) begin
            if (sb.size() == 0) push_snapshot();
            else if (drop_m < 255) drop_m++;
        end
        @(negedge CLK);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0; drop_m = 0;
        RST = 1'b0; capture = 1'b1; out_ready = 1'b1;
        fill_random();

        // Reset held with capture asserted and random Y
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            fill_random();
            chk_zero_outputs("reset");
        end
        RST = 1'b1;
        capture = 1'b0;
        tick(0, 0);
        tick(0, 1);

        // Single drain with ready high
        fill_pattern();
        tick(1, 1);
        for (int i = 0; i < 3; i++) tick(0, 1);
        chk("r3c5", DW'(out_data[5*RW +: RW]), DW'(32'h0305));
        for (int i = 0; i < 14; i++) tick(0, 1);

        // Backpressure with Y churning after the snapshot
        fill_random();
        tick(1, 1);
        for (int i = 0; i < 80 && sb.size() > 0; i++) begin
            fill_random();
            tick(0, (i % 4 == 0) || (i % 4 == 3));
        end
        tick(0, 1);

        // Captures while busy are dropped; drained data is the first snapshot
        fill_pattern();
        tick(1, 1);
        for (int i = 0; i < 16; i++) begin
            fill_random();
            tick((i == 2) || (i == 5) || (i == 9), 1);
        end
        chk("drop3", DW'(drop_cnt), DW'(8'd3));

        // Back-to-back: capture on the row-15 accept
        fill_pattern();
        tick(1, 1);
        for (int i = 0; i < 15; i++) tick(0, 1);
        drop_before = drop_cnt;
        fill_const(32'hDEADBEEF);
        tick(1, 1);
        chk("b2b_row",  DW'(out_row),  '0);
        chk("b2b_data", out_data,      {HPE{32'hDEADBEEF}});
        chk("b2b_busy", DW'(busy),     DW'(1'b1));
        chk("b2b_drop", DW'(drop_cnt), DW'(drop_before));

        // Saturation: 300 captures during a stall
        for (int i = 0; i < 300; i++) tick(1, 0);
        chk("drop_sat", DW'(drop_cnt), DW'(8'd255));
        for (int i = 0; i < 17; i++) tick(0, 1);

        // Reset mid-drain
        fill_pattern();
        tick(1, 1);
        for (int i = 0; i < 7; i++) tick(0, 1);
        chk("pre_rst_row", DW'(out_row), DW'(4'd7));
        #2 RST = 1'b0;
        #1 chk_zero_outputs("async_rst");
        sb.delete();
        drop_m  = 0;
        capture = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk_zero_outputs("rst_hold");
        RST = 1'b1;
        tick(0, 1);
        fill_random();
        tick(1, 1);
        chk("restart_row", DW'(out_row), '0);
        for (int i = 0; i < 17; i++) tick(0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
